// File: rtl/ifetch_unit.sv
// Instruction fetch / PC stage.
// Owns the program counter, runs a request/acknowledge read on instruction
// memory, latches the returned word into the instruction register and exposes
// the decoded instruction fields to the control FSM and datapath.
//
// Memory handshake: IMEM_REQ acts as "valid" for IMEM_ADDR. Once raised, it is
// held with IMEM_ADDR stable until the first cycle IMEM_ACK=1 is sampled
// (that cycle's IMEM_DATA is captured) or until the timeout expires. IMEM_ACK
// has no meaning while IMEM_REQ=0 and is ignored in that case.
module ifetch_unit #(
    parameter int              AW        = 16,
    parameter logic [AW-1:0]   RESET_VEC = '0,
    parameter int              TIMEOUT   = 15
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          FETCH_START,
    input  logic          PC_WRITE,
    input  logic          PC_SEL,
    input  logic          BR_SEL,
    output logic          IMEM_REQ,
    output logic [AW-1:0] IMEM_ADDR,
    input  logic          IMEM_ACK,
    input  logic [31:0]   IMEM_DATA,
    output logic [3:0]    OPCODE,
    output logic [3:0]    MM,
    output logic [3:0]    RD,
    output logic [3:0]    RS1,
    output logic [15:0]   IMM,
    output logic          IR_VALID,
    output logic          BUSY,
    output logic          FAULT,
    output logic [AW-1:0] PC
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Last value of the wait counter before the fetch is declared dead.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [31:0]   ir_q, ir_d;
    logic          ir_valid_q, ir_valid_d;
    logic          busy_q, busy_d;
    logic          fault_q, fault_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          pend_q, pend_d;

    logic          branch;
    logic [AW-1:0] imm_zext;
    logic [AW-1:0] imm_sext;
    logic [AW-1:0] target;
    logic [AW-1:0] pc_inc;

    // Immediate fitted to the address width: zero-extended for absolute
    // targets, sign-extended for PC-relative offsets (truncated if AW < 16).
    always_comb begin
        imm_zext = '0;
        imm_sext = {AW{ir_q[15]}};
        for (int i = 0; i < AW && i < 16; i++) begin
            imm_zext[i] = ir_q[i];
            imm_sext[i] = ir_q[i];
        end
    end

    // Branch target; relative branches are taken from the PC of the most
    // recently issued fetch, not from the already-incremented PC.
    always_comb begin
        branch = PC_WRITE & PC_SEL;
        target = BR_SEL ? imm_zext : (fetch_pc_q + imm_sext);
        pc_inc = fetch_pc_q + AW'(1);
    end

    // Next-state and next-output logic for the fetch FSM.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        busy_d     = busy_q;
        fault_d    = fault_q;
        req_d      = req_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (FETCH_START) begin
                    state_d    = S_REQ;
                    req_d      = 1'b1;
                    addr_d     = pc_q;
                    fetch_pc_d = pc_q;
                    busy_d     = 1'b1;
                    ir_valid_d = 1'b0;
                    fault_d    = 1'b0;
                    cnt_d      = '0;
                    pend_d     = 1'b0;
                end
            end
            S_REQ: begin
                // FETCH_START is deliberately ignored while a fetch is open.
                if (IMEM_ACK) begin
                    state_d    = S_DONE;
                    ir_d       = IMEM_DATA;
                    ir_valid_d = 1'b1;
                    req_d      = 1'b0;
                    busy_d     = 1'b0;
                    pend_d     = 1'b0;
                    // A branch taken during this fetch already owns the PC.
                    if (!pend_q) begin
                        pc_d = pc_inc;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    fault_d = 1'b1;
                    pend_d  = 1'b0;
                    cnt_d   = cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Branches override any increment. If the fetch stays open after this
        // edge, remember it so completion does not clobber the target.
        if (branch) begin
            pc_d = target;
            if (state_d == S_REQ) begin
                pend_d = 1'b1;
            end
        end
    end

    // State register; reset wins over everything, including a same-cycle ACK.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_VEC;
            fetch_pc_q <= RESET_VEC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            busy_q     <= busy_d;
            fault_q    <= fault_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
        end
    end

    // Decoded fields are plain slices of IR and hold between fetches.
    always_comb begin
        OPCODE    = ir_q[31:28];
        MM        = ir_q[27:24];
        RD        = ir_q[23:20];
        RS1       = ir_q[19:16];
        IMM       = ir_q[15:0];
        IR_VALID  = ir_valid_q;
        BUSY      = busy_q;
        FAULT     = fault_q;
        IMEM_REQ  = req_q;
        IMEM_ADDR = addr_q;
        PC        = pc_q;
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: reset/zero-wait fetch, a vector table
// of fetches, hand-written corner sequences and a randomized phase checked
// against a transaction-level reference model.
module tb_ifetch_unit;

    localparam int AW      = 16;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_start;
    logic          pc_write;
    logic          pc_sel;
    logic          br_sel;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_data;
    logic [3:0]    opcode;
    logic [3:0]    mm;
    logic [3:0]    rd;
    logic [3:0]    rs1;
    logic [15:0]   imm;
    logic          ir_valid;
    logic          busy;
    logic          fault;
    logic [AW-1:0] pc;

    ifetch_unit #(
        .AW        (AW),
        .RESET_VEC (16'h0000),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .FETCH_START (fetch_start),
        .PC_WRITE    (pc_write),
        .PC_SEL      (pc_sel),
        .BR_SEL      (br_sel),
        .IMEM_REQ    (imem_req),
        .IMEM_ADDR   (imem_addr),
        .IMEM_ACK    (imem_ack),
        .IMEM_DATA   (imem_data),
        .OPCODE      (opcode),
        .MM          (mm),
        .RD          (rd),
        .RS1         (rs1),
        .IMM         (imm),
        .IR_VALID    (ir_valid),
        .BUSY        (busy),
        .FAULT       (fault),
        .PC          (pc)
    );

    // Clock
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] data;
        int          waits;
        logic [3:0]  op;
        logic [3:0]  mmv;
        logic [3:0]  rdv;
        logic [3:0]  rs1v;
        logic [15:0] immv;
    } vec_t;

    vec_t vecs[5];

    // Scoreboard compare
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Advance one clock; inputs set after this are sampled at the next edge
    // and outputs read here are settled post-edge values.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fetch_start = 1'b0;
        pc_write    = 1'b0;
        pc_sel      = 1'b0;
        br_sel      = 1'b0;
        imem_ack    = 1'b0;
    endtask

    task automatic start_fetch();
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
    endtask

    task automatic do_branch(input logic abs_sel);
        pc_write = 1'b1;
        pc_sel   = 1'b1;
        br_sel   = abs_sel;
        step();
        clear_inputs();
    endtask

    // Full fetch: address/handshake checked every REQ cycle, ACK after waits.
    task automatic fetch(input int waits, input logic [31:0] data, input logic [AW-1:0] addr, input string tag);
        start_fetch();
        check({tag, "_valid_low"}, ir_valid, 1'b0);
        for (int i = 0; i < waits; i++) begin
            check({tag, "_req"}, imem_req, 1'b1);
            check({tag, "_addr"}, imem_addr, addr);
            check({tag, "_busy"}, busy, 1'b1);
            step();
        end
        check({tag, "_addr_ack"}, imem_addr, addr);
        imem_ack  = 1'b1;
        imem_data = data;
        step();
        imem_ack  = 1'b0;
    endtask

    logic [15:0] exp_pc;
    logic [15:0] m_pc;
    logic [15:0] m_fetch_pc;
    logic [31:0] m_ir;
    logic [15:0] tgt;
    logic [31:0] ack_data;
    logic [31:0] d;
    logic [31:0] exp_word;
    logic        bs;
    logic        tmo;
    logic        branched;
    logic        ackc;
    int          waits;
    int          last;
    int          br_at;

    initial begin
        vecs[0] = '{32'h1A2BC3D4, 1, 4'h1, 4'hA, 4'h2, 4'hB, 16'hC3D4};
        vecs[1] = '{32'hF0E1D2C3, 0, 4'hF, 4'h0, 4'hE, 4'h1, 16'hD2C3};
        vecs[2] = '{32'h56789ABC, 3, 4'h5, 4'h6, 4'h7, 4'h8, 16'h9ABC};
        vecs[3] = '{32'h00000000, 2, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000};
        vecs[4] = '{32'hFFFFFFFF, 0, 4'hF, 4'hF, 4'hF, 4'hF, 16'hFFFF};

        // Reset
        clear_inputs();
        imem_data = 32'h0;
        rst = 1'b1;
        step();
        step();
        check("rst_pc", pc, 16'h0000);
        check("rst_valid", ir_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 16'h0000);
        check("rst_ir", {opcode, mm, rd, rs1, imm}, 32'h0);
        rst = 1'b0;
        step();

        // Zero-wait fetch: IR_VALID two cycles after the pulse
        start_fetch();
        check("zw_req", imem_req, 1'b1);
        check("zw_addr", imem_addr, 16'h0000);
        check("zw_busy", busy, 1'b1);
        check("zw_valid_low", ir_valid, 1'b0);
        imem_ack  = 1'b1;
        imem_data = 32'h81230005;
        step();
        imem_ack = 1'b0;
        check("zw_valid", ir_valid, 1'b1);
        check("zw_opcode", opcode, 4'h8);
        check("zw_mm", mm, 4'h1);
        check("zw_rd", rd, 4'h2);
        check("zw_rs1", rs1, 4'h3);
        check("zw_imm", imm, 16'h0005);
        check("zw_pc", pc, 16'h0001);
        check("zw_req_low", imem_req, 1'b0);
        check("zw_busy_low", busy, 1'b0);

        // Vector table of back-to-back fetches
        exp_pc = 16'h0001;
        for (int v = 0; v < 5; v++) begin
            fetch(vecs[v].waits, vecs[v].data, exp_pc, "vec");
            exp_pc = exp_pc + 16'd1;
            check("vec_valid", ir_valid, 1'b1);
            check("vec_fields", {opcode, mm, rd, rs1, imm},
                  {vecs[v].op, vecs[v].mmv, vecs[v].rdv, vecs[v].rs1v, vecs[v].immv});
            check("vec_pc", pc, exp_pc);
        end

        // Wait states with a stray FETCH_START mid-wait (PC=6)
        start_fetch();
        for (int i = 0; i < 5; i++) begin
            check("ws_req", imem_req, 1'b1);
            check("ws_addr", imem_addr, 16'h0006);
            check("ws_busy", busy, 1'b1);
            fetch_start = (i == 1);
            imem_ack    = (i == 4);
            imem_data   = 32'h71234567;
            step();
        end
        clear_inputs();
        check("ws_valid", ir_valid, 1'b1);
        check("ws_ir", {opcode, mm, rd, rs1, imm}, 32'h71234567);
        check("ws_pc", pc, 16'h0007);

        // Timeout: 15 REQ cycles then FAULT; stray FETCH_START must not restart
        start_fetch();
        for (int i = 0; i < TIMEOUT; i++) begin
            check("to_req", imem_req, 1'b1);
            fetch_start = (i == 7);
            step();
        end
        fetch_start = 1'b0;
        check("to_fault", fault, 1'b1);
        check("to_req_low", imem_req, 1'b0);
        check("to_busy_low", busy, 1'b0);
        check("to_valid", ir_valid, 1'b0);
        check("to_pc", pc, 16'h0007);
        check("to_ir", {opcode, mm, rd, rs1, imm}, 32'h71234567);
        step();
        check("to_fault_sticky", fault, 1'b1);
        start_fetch();
        check("to_fault_clr", fault, 1'b0);
        check("to_refetch_addr", imem_addr, 16'h0007);
        imem_ack  = 1'b1;
        imem_data = 32'h20000010;
        step();
        imem_ack = 1'b0;
        check("to_refetch_pc", pc, 16'h0008);

        // Absolute branch to 0x0010, fetch IMM=0xFFFC, relative branch
        do_branch(1'b1);
        check("abs_pc_10", pc, 16'h0010);
        fetch(0, 32'h3000FFFC, 16'h0010, "rel");
        check("rel_fetch_pc", pc, 16'h0011);
        do_branch(1'b0);
        check("rel_pc", pc, 16'h000C);
        fetch(1, 32'h40000040, 16'h000C, "abs");
        do_branch(1'b1);
        check("abs_pc", pc, 16'h0040);
        pc_write = 1'b1;
        pc_sel   = 1'b0;
        step();
        clear_inputs();
        check("pcw_nosel_pc", pc, 16'h0040);

        // Race A: relative branch during REQ (0x40 + 0x40), no +1 on ACK
        start_fetch();
        pc_write = 1'b1;
        pc_sel   = 1'b1;
        br_sel   = 1'b0;
        step();
        clear_inputs();
        check("raceA_pc_early", pc, 16'h0080);
        check("raceA_addr", imem_addr, 16'h0040);
        check("raceA_req", imem_req, 1'b1);
        imem_ack  = 1'b1;
        imem_data = 32'h50000008;
        step();
        imem_ack = 1'b0;
        check("raceA_pc", pc, 16'h0080);
        check("raceA_valid", ir_valid, 1'b1);

        // Race B: absolute branch in the ACK cycle uses the old IMM (8)
        start_fetch();
        imem_ack  = 1'b1;
        imem_data = 32'h60000003;
        pc_write  = 1'b1;
        pc_sel    = 1'b1;
        br_sel    = 1'b1;
        step();
        clear_inputs();
        check("raceB_pc", pc, 16'h0008);
        check("raceB_ir", {opcode, mm, rd, rs1, imm}, 32'h60000003);

        // Reset during REQ with a same-cycle ACK
        start_fetch();
        rst       = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 32'hDEADBEEF;
        step();
        rst      = 1'b0;
        imem_ack = 1'b0;
        check("rstmid_ir", {opcode, mm, rd, rs1, imm}, 32'h0);
        check("rstmid_valid", ir_valid, 1'b0);
        check("rstmid_pc", pc, 16'h0000);
        check("rstmid_req", imem_req, 1'b0);
        check("rstmid_busy", busy, 1'b0);

        // PC wrap from 0xFFFF
        fetch(0, 32'h0000FFFF, 16'h0000, "wrap0");
        do_branch(1'b1);
        check("wrap_pc_top", pc, 16'hFFFF);
        fetch(2, 32'h90000001, 16'hFFFF, "wrap");
        check("wrap_pc", pc, 16'h0000);

        // Randomized transactions against a transaction-level model
        m_pc       = 16'h0000;
        m_fetch_pc = 16'hFFFF;
        m_ir       = 32'h90000001;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                bs = 1'($urandom_range(0, 1));
                do_branch(bs);
                m_pc = bs ? m_ir[15:0] : (m_fetch_pc + m_ir[15:0]);
                check("rnd_idle_br_pc", pc, m_pc);
            end
            m_fetch_pc = m_pc;
            start_fetch();
            waits    = $urandom_range(0, TIMEOUT + 3);
            tmo      = (waits >= TIMEOUT);
            last     = tmo ? TIMEOUT - 1 : waits;
            br_at    = $urandom_range(0, 2 * last + 2);
            branched = 1'b0;
            ack_data = 32'h0;
            tgt      = 16'h0;
            for (int c = 0; c <= last; c++) begin
                check("rnd_req", imem_req, 1'b1);
                check("rnd_addr", imem_addr, m_fetch_pc);
                d         = $urandom;
                imem_data = d;
                ackc      = !tmo && (c == waits);
                imem_ack  = ackc;
                if (ackc) ack_data = d;
                if (c == br_at) begin
                    bs       = 1'($urandom_range(0, 1));
                    pc_write = 1'b1;
                    pc_sel   = 1'b1;
                    br_sel   = bs;
                    tgt      = bs ? m_ir[15:0] : (m_fetch_pc + m_ir[15:0]);
                    branched = 1'b1;
                end else begin
                    pc_write = 1'($urandom_range(0, 1));
                    pc_sel   = 1'b0;
                    br_sel   = 1'($urandom_range(0, 1));
                end
                fetch_start = ($urandom_range(0, 3) == 0);
                step();
            end
            clear_inputs();
            if (!tmo) begin
                m_pc = branched ? tgt : (m_fetch_pc + 16'd1);
                m_ir = ack_data;
                exp_q.push_back(ack_data);
            end else begin
                m_pc = branched ? tgt : m_fetch_pc;
            end
            check("rnd_pc", pc, m_pc);
            check("rnd_valid", ir_valid, !tmo);
            check("rnd_fault", fault, tmo);
            check("rnd_busy", busy, 1'b0);
            check("rnd_req_low", imem_req, 1'b0);
            if (!tmo) begin
                exp_word = exp_q.pop_front();
                check("rnd_ir", {opcode, mm, rd, rs1, imm}, exp_word);
            end
        end

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
